fetch_prefetch_queue: RTL and testbench

Instruction fetch front-end placed directly upstream of `static_branch_predict`. Issues word-aligned instruction requests to the instruction memory port and buffers returned words with their PCs in a small FIFO. Presents the FIFO head to the predictor as `fetch_rdata_o`, `fetch_pc_o` and `fetch_valid_o`. Consumes the predictor's `predict_branch_taken_o` and `predict_branch_pc_o`, plus the execute-stage redirect, to steer the fetch address and flush stale entries.

---
 rtl/fetch_prefetch_queue_if.sv | 33 +++
 rtl/fetch_prefetch_queue.sv | 106 ++++++++++
 tb/tb_fetch_prefetch_queue.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bundle: instruction memory port, FIFO head towards the
// predictor/decode, and the two redirect sources.
interface fetch_prefetch_queue_if;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        fetch_valid_o;
    logic [31:0] fetch_rdata_o;
    logic [31:0] fetch_pc_o;
    logic        fetch_ready_i;
    logic        predict_taken_i;
    logic [31:0] predict_pc_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    modport master (
        output instr_req_o, instr_addr_o,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i,
        output fetch_valid_o, fetch_rdata_o, fetch_pc_o,
        input  fetch_ready_i, predict_taken_i, predict_pc_i,
        input  redirect_i, redirect_pc_i
    );

    modport slave (
        input  instr_req_o, instr_addr_o,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i,
        input  fetch_valid_o, fetch_rdata_o, fetch_pc_o,
        output fetch_ready_i, predict_taken_i, predict_pc_i,
        output redirect_i, redirect_pc_i
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetcher: one outstanding word request, PC-tagged FIFO,
// flushed and re-steered by predictor-taken consumes and execute redirects.
//   state | meaning
//   IDLE  | no request, nothing outstanding (FIFO full)
//   REQ   | request driven, waiting for grant
//   WAIT  | request granted, response pending
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    fetch_prefetch_queue_if.master bus
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_e;

    state_e        state_q, state_d;
    logic          req_q;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   req_pc_q;
    logic          discard_q, discard_d;
    logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];

    logic head_valid, consume, pred_flush, flush, gnt_now, rsp_now, push;

    always_comb begin
        head_valid = (count_q != '0);
        consume    = head_valid & bus.fetch_ready_i;
        pred_flush = consume & bus.predict_taken_i;
        flush      = bus.redirect_i | pred_flush;
        gnt_now    = (state_q == REQ) & bus.instr_gnt_i;
        rsp_now    = (state_q == WAIT) & bus.instr_rvalid_i;
        push       = rsp_now & ~discard_q & ~flush;

        fpc_d = fpc_q;
        if (bus.redirect_i)   fpc_d = bus.redirect_pc_i & ~32'h3;
        else if (pred_flush)  fpc_d = bus.predict_pc_i & ~32'h3;
        else if (gnt_now)     fpc_d = fpc_q + 32'd4;

        if (flush) begin
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
        end else begin
            count_d = count_q + (AW+1)'(push) - (AW+1)'(consume);
            wptr_d  = wptr_q + AW'(push);
            rptr_d  = rptr_q + AW'(consume);
        end

        // A flush with a request in flight must swallow that stale response.
        discard_d = discard_q;
        if (rsp_now) discard_d = 1'b0;
        if (flush && (gnt_now || ((state_q == WAIT) && !bus.instr_rvalid_i)))
            discard_d = 1'b1;

        state_d = state_q;
        unique case (state_q)
            IDLE:    if (count_d < DEPTH_C) state_d = REQ;
            REQ:     if (bus.instr_gnt_i) state_d = WAIT;
            WAIT:    if (bus.instr_rvalid_i) state_d = (count_d < DEPTH_C) ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            fpc_q     <= BOOT_ADDR;
            req_pc_q  <= BOOT_ADDR;
            discard_q <= 1'b0;
            rptr_q    <= '0;
            wptr_q    <= '0;
            count_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= BOOT_ADDR;
            end
        end else begin
            state_q   <= state_d;
            req_q     <= (state_d == REQ);
            fpc_q     <= fpc_d;
            discard_q <= discard_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            if (gnt_now) req_pc_q <= fpc_q;
            if (push) begin
                data_q[wptr_q] <= bus.instr_rdata_i;
                pc_q[wptr_q]   <= req_pc_q;
            end
        end
    end

    assign bus.instr_req_o   = req_q;
    assign bus.instr_addr_o  = fpc_q;
    assign bus.fetch_valid_o = head_valid;
    assign bus.fetch_rdata_o = data_q[rptr_q];
    assign bus.fetch_pc_o    = pc_q[rptr_q];
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench for fetch_prefetch_queue: a memory/decode driver keeps a
// queue-level reference model, a negedge monitor pops and compares head words.
module tb_fetch_prefetch_queue;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BOOT  = 32'h0000_0080;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    fetch_prefetch_queue_if bus();

    fetch_prefetch_queue #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t      exp_q[$];
    entry_t      mon_e;
    int          checks   = 0;
    int          failures = 0;
    bit          run      = 1'b0;

    // reference model: fetch PC, one outstanding request and whether it went stale
    logic [31:0] fpc_m;
    logic [31:0] pend_pc;
    bit          pending, stale;
    bit          g_gnt, g_rsp, g_redir, g_pflush;
    logic [31:0] g_rdata, g_rpc, g_ppc;

    logic [31:0] targets [6] = '{32'h0000_00FC, 32'h0000_2002, 32'hFFFF_FFF4,
                                 32'hFFFF_FFFE, 32'h0000_0100, 32'h0000_0000};

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick_target();
        if ($urandom_range(0, 1) == 0) return targets[$urandom_range(0, 5)];
        return $urandom();
    endfunction

    task automatic drive_idle();
        bus.instr_gnt_i     = 1'b0;
        bus.instr_rvalid_i  = 1'b0;
        bus.instr_rdata_i   = '0;
        bus.fetch_ready_i   = 1'b0;
        bus.predict_taken_i = 1'b0;
        bus.predict_pc_i    = '0;
        bus.redirect_i      = 1'b0;
        bus.redirect_pc_i   = '0;
    endtask

    task automatic do_reset(input bit late_rvalid);
        run    = 1'b0;
        rst_ni = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("rst_req",   32'(bus.instr_req_o),   32'd0);
        check32("rst_valid", 32'(bus.fetch_valid_o), 32'd0);
        check32("rst_addr",  bus.instr_addr_o,       BOOT);
        check32("rst_rdata", bus.fetch_rdata_o,      32'd0);
        check32("rst_pc",    bus.fetch_pc_o,         BOOT);
        exp_q.delete();
        fpc_m    = BOOT;
        pending  = 1'b0;
        stale    = 1'b0;
        g_gnt    = 1'b0;
        g_rsp    = 1'b0;
        g_redir  = 1'b0;
        g_pflush = 1'b0;
        rst_ni   = 1'b1;
        bus.instr_rvalid_i = late_rvalid;
        bus.instr_rdata_i  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.instr_rvalid_i = 1'b0;
        run = 1'b1;
    endtask

    // Called at posedge+1: retire the effects of the previous cycle into the
    // model, check the request line, then drive the next cycle's stimulus.
    task automatic step(input int ready_pct, input int redir_pct, input int pred_pct,
                        input bit force_redir, input logic [31:0] force_pc);
        bit     flush;
        bit     tk;
        entry_t ne;
        flush = g_redir || g_pflush;
        if (g_rsp) begin
            if (!stale && !flush) begin
                ne.pc   = pend_pc;
                ne.data = g_rdata;
                exp_q.push_back(ne);
            end
            pending = 1'b0;
            stale   = 1'b0;
        end
        if (g_gnt) begin
            pending = 1'b1;
            pend_pc = fpc_m;
            stale   = 1'b0;
            fpc_m   = fpc_m + 32'd4;
        end
        if (flush) begin
            exp_q.delete();
            if (pending) stale = 1'b1;
            fpc_m = g_redir ? (g_rpc & ~32'h3) : (g_ppc & ~32'h3);
        end

        check32("instr_req", 32'(bus.instr_req_o),
                32'(!pending && (exp_q.size() < int'(DEPTH))));

        g_gnt = bus.instr_req_o && ($urandom_range(0, 9) < 7);
        if (g_gnt) check32("grant_addr", bus.instr_addr_o, fpc_m);
        bus.instr_gnt_i = g_gnt;

        g_rsp   = pending && ($urandom_range(0, 9) < 6);
        g_rdata = $urandom();
        bus.instr_rvalid_i = g_rsp;
        bus.instr_rdata_i  = g_rdata;

        bus.fetch_ready_i = ($urandom_range(0, 99) < ready_pct);

        g_redir = force_redir || ($urandom_range(0, 99) < redir_pct);
        g_rpc   = force_redir ? force_pc : pick_target();
        bus.redirect_i    = g_redir;
        bus.redirect_pc_i = g_rpc;

        tk    = ($urandom_range(0, 99) < pred_pct);
        g_ppc = pick_target();
        bus.predict_taken_i = tk;
        bus.predict_pc_i    = g_ppc;
        g_pflush = !g_redir && tk && bus.fetch_ready_i && (exp_q.size() != 0);
    endtask

    always @(negedge clk) begin
        if (run && rst_ni) begin
            check32("head_valid", 32'(bus.fetch_valid_o), 32'(exp_q.size() != 0));
            if (bus.fetch_valid_o && bus.fetch_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL head_unexpected actual_pc=%h required=none", bus.fetch_pc_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check32("head_pc",    bus.fetch_pc_o,    mon_e.pc);
                    check32("head_rdata", bus.fetch_rdata_o, mon_e.data);
                end
            end
        end
    end

    initial begin
        drive_idle();
        do_reset(1'b0);
        // streaming with decode always ready
        for (int i = 0; i < 400; i++) begin
            step(100, 0, 0, 1'b0, 32'd0);
            @(posedge clk); #1;
        end
        // decode stalled: FIFO fills and requests must stop
        for (int i = 0; i < 200; i++) begin
            step(0, 0, 0, 1'b0, 32'd0);
            @(posedge clk); #1;
        end
        // mixed traffic with both redirect sources
        for (int i = 0; i < 3000; i++) begin
            step(70, 6, 20, 1'b0, 32'd0);
            @(posedge clk); #1;
        end
        // reset mid-flight, with a late response in the release cycle
        do_reset(1'b1);
        // steer near the top of the address space and run across the wrap
        step(90, 0, 0, 1'b1, 32'hFFFF_FFF8);
        @(posedge clk); #1;
        for (int i = 0; i < 300; i++) begin
            step(90, 0, 0, 1'b0, 32'd0);
            @(posedge clk); #1;
        end
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
